// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the slot instruction on a taken redirect.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [15:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic [31:0] Addr,
  input  logic [31:0] InstrIn,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPcPlus4,
  output logic        IfIdValid,
  output logic        Fault,
  output logic [31:0] FaultPc
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] IMEM_WORDS_U = IMEM_WORDS;

  state_t      state_p0, state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] instr_p1, pc4_p1;
  logic        vld_p1;
  logic        fault_q;
  logic [31:0] fault_pc_q;

  logic        illegal;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        pc_ld;
  logic [31:0] pc_d;
  logic        ifid_cap;
  logic        ifid_bub;
  logic        fault_set;

  function automatic logic is_illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= IMEM_WORDS_U);
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] off);
    logic signed [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return pc4 + $unsigned(disp);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

  assign illegal  = is_illegal(pc_p0);
  assign pc_plus4 = pc_p0 + 32'd4;
  // Redirects only act on a real instruction sitting in IF/ID; Jump beats Branch.
  assign redirect = vld_p1 && (Jump || Branch);
  assign target   = Jump ? jump_target(pc4_p1, JumpIndex)
                         : branch_target(pc4_p1, BranchOffset);

  always_ff @(posedge Clk) begin
    if (Reset) state_p0 <= BOOT;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      BOOT:    state_nxt = RUN;
      RUN:     if (illegal) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_ld     = 1'b0;
    pc_d      = pc_p0;
    ifid_cap  = 1'b0;
    ifid_bub  = 1'b0;
    fault_set = 1'b0;
    unique case (state_p0)
      RUN: begin
        if (illegal) begin
          fault_set = 1'b1;
          ifid_bub  = 1'b1;
        end else if (!Stall) begin
          pc_ld = 1'b1;
          if (redirect) begin
            pc_d = target;
`ifdef BRANCH_DELAY_SLOT_EN
            ifid_cap = 1'b1;
`else
            ifid_bub = 1'b1;
`endif
          end else begin
            pc_d     = pc_plus4;
            ifid_cap = 1'b1;
          end
        end
      end
      HALT:    ifid_bub = 1'b1;
      default: ;
    endcase
  end

  // Stage 0 -> 1: PC update and IF/ID capture on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_p0      <= RESET_PC;
      instr_p1   <= 32'd0;
      pc4_p1     <= 32'd0;
      vld_p1     <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      if (pc_ld) pc_p0 <= pc_d;
      if (ifid_cap) begin
        instr_p1 <= InstrIn;
        pc4_p1   <= pc_plus4;
        vld_p1   <= 1'b1;
      end else if (ifid_bub) begin
        instr_p1 <= 32'd0;
        pc4_p1   <= 32'd0;
        vld_p1   <= 1'b0;
      end
      if (fault_set) begin
        fault_q    <= 1'b1;
        fault_pc_q <= pc_p0;
      end
    end
  end

  assign Addr        = pc_p0;
  assign IfIdInstr   = instr_p1;
  assign IfIdPcPlus4 = pc4_p1;
  assign IfIdValid   = vld_p1;
  assign Fault       = fault_q;
  assign FaultPc     = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized traffic
// checked every cycle against a behavioural fetch model.
module tb_instruction_fetch_stage;

  localparam int WORDS = 32;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic [15:0] BranchOffset = 16'd0;
  logic        Jump = 1'b0;
  logic [25:0] JumpIndex = 26'd0;
  logic [31:0] Addr;
  logic [31:0] InstrIn;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPcPlus4;
  logic        IfIdValid;
  logic        Fault;
  logic [31:0] FaultPc;

  // Second instance with a misaligned reset PC.
  logic        rst2 = 1'b1;
  logic        zero1 = 1'b0;
  logic [15:0] zero16 = 16'd0;
  logic [25:0] zero26 = 26'd0;
  logic [31:0] zero32 = 32'd0;
  logic [31:0] addr2, instr2, pc4_2, fpc2;
  logic        vld2, fault2;

  logic [31:0] mem [WORDS];

  int n_chk = 0;
  int n_err = 0;

  // Behavioural reference state
  bit [31:0] m_pc, m_instr, m_p4, m_fpc;
  bit        m_valid, m_fault, m_boot, m_halt;

  always #5 Clk = ~Clk;

  assign InstrIn = (Addr[1:0] == 2'b00 && Addr[31:2] < 30'd32) ? mem[Addr[6:2]] : 32'hDEAD_BEEF;

  instruction_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchOffset(BranchOffset), .Jump(Jump), .JumpIndex(JumpIndex),
    .Addr(Addr), .InstrIn(InstrIn), .IfIdInstr(IfIdInstr),
    .IfIdPcPlus4(IfIdPcPlus4), .IfIdValid(IfIdValid), .Fault(Fault), .FaultPc(FaultPc)
  );

  instruction_fetch_stage #(.RESET_PC(32'h2), .IMEM_WORDS(WORDS)) dut2 (
    .Clk(Clk), .Reset(rst2), .Stall(zero1), .Branch(zero1),
    .BranchOffset(zero16), .Jump(zero1), .JumpIndex(zero26),
    .Addr(addr2), .InstrIn(zero32), .IfIdInstr(instr2),
    .IfIdPcPlus4(pc4_2), .IfIdValid(vld2), .Fault(fault2), .FaultPc(fpc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_capture(input bit [31:0] instr);
    m_instr = instr;
    m_p4    = m_pc + 32'd4;
    m_valid = 1'b1;
  endtask

  task automatic m_bubble();
    m_instr = 0;
    m_p4    = 0;
    m_valid = 0;
  endtask

  // One clock of fetch behaviour, applied from the inputs present before the edge.
  task automatic model_step(input bit rst, input bit st, input bit br,
                            input bit [15:0] off, input bit jp, input bit [25:0] ji);
    bit [31:0] tgt;
    bit        take_j, take_b;
    if (rst) begin
      m_pc = 32'h0; m_bubble();
      m_fault = 0; m_fpc = 0; m_boot = 1; m_halt = 0;
      return;
    end
    if (m_halt) return;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    if ((m_pc % 4) != 0 || (m_pc / 4) >= WORDS) begin
      m_fault = 1; m_fpc = m_pc; m_bubble(); m_halt = 1;
      return;
    end
    if (st) return;
    take_j = jp && m_valid;
    take_b = br && m_valid && !take_j;
    if (take_j) tgt = (m_p4 & 32'hF000_0000) + (32'(ji) * 4);
    else        tgt = m_p4 + 32'(int'($signed(off)) * 4);
    if (take_j || take_b) begin
`ifdef BRANCH_DELAY_SLOT_EN
      m_capture(mem[m_pc / 4]);
`else
      m_bubble();
`endif
      m_pc = tgt;
    end else begin
      m_capture(mem[m_pc / 4]);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all();
    chk("addr",   Addr,        m_pc);
    chk("instr",  IfIdInstr,   m_instr);
    chk("pc4",    IfIdPcPlus4, m_p4);
    chk("valid",  32'(IfIdValid), 32'(m_valid));
    chk("fault",  32'(Fault),  32'(m_fault));
    chk("faultpc", FaultPc,    m_fpc);
  endtask

  task automatic step(input bit rst, input bit st, input bit br,
                      input bit [15:0] off, input bit jp, input bit [25:0] ji);
    Reset = rst; Stall = st; Branch = br; BranchOffset = off; Jump = jp; JumpIndex = ji;
    model_step(rst, st, br, off, jp, ji);
    @(posedge Clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = (i < 4) ? 32'h2008_0001 + i : $urandom;

    // Free run from reset; the misaligned-reset instance runs alongside.
    step(1, 0, 0, 0, 0, 0);
    chk("rst_addr", Addr, 32'h0);
    chk("rst_valid", 32'(IfIdValid), 32'h0);
    chk("d2_rst_addr", addr2, 32'h2);
    chk("d2_rst_fault", 32'(fault2), 32'h0);
    rst2 = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk("boot_addr", Addr, 32'h0);
    chk("boot_valid", 32'(IfIdValid), 32'h0);
    chk("d2_boot_fault", 32'(fault2), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("run_addr", Addr, 32'h4);
    chk("first_instr", IfIdInstr, 32'h2008_0001);
    chk("first_pc4", IfIdPcPlus4, 32'h4);
    chk("d2_fault", 32'(fault2), 32'h1);
    chk("d2_faultpc", fpc2, 32'h2);
    chk("d2_valid", 32'(vld2), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("run_addr8", Addr, 32'h8);

    // Stall two cycles at PC=8, then a backwards branch to 0.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 16'hFFFE, 0, 0);
    chk("stall_addr", Addr, 32'h8);
    chk("stall_pc4", IfIdPcPlus4, 32'h8);
    step(0, 0, 1, 16'hFFFE, 0, 0);
    chk("branch_addr", Addr, 32'h0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    chk("seq_addr10", Addr, 32'h10);

    // Jump beats Branch; then redirect requests against a possible bubble.
    step(0, 0, 1, 16'h0003, 1, 26'd5);
    chk("jump_addr", Addr, 32'h14);
    step(0, 0, 1, 16'h0003, 1, 26'd5);
`ifndef BRANCH_DELAY_SLOT_EN
    chk("bubble_ignore", Addr, 32'h18);
`endif
    step(0, 0, 0, 0, 0, 0);

    // Jump off the end of memory, then halt until reset.
    step(0, 0, 0, 0, 1, 26'd32);
    chk("jump_oob", Addr, 32'h80);
    step(0, 1, 1, 16'h0004, 0, 0);
    chk("halt_fault", 32'(Fault), 32'h1);
    chk("halt_fpc", FaultPc, 32'h80);
    step(0, 0, 1, 16'h0004, 1, 26'd1);
    chk("halt_addr", Addr, 32'h80);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_clear", 32'(Fault), 32'h0);

    // Random traffic, including stalls, redirects, faults and resets.
    for (int n = 0; n < 800; n++) begin
      bit r, s, b, j;
      bit [15:0] o;
      bit [25:0] x;
      r = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 99) < 30);
      s = $urandom_range(0, 99) < 20;
      b = $urandom_range(0, 99) < 25;
      j = $urandom_range(0, 99) < 12;
      o = 16'($urandom_range(0, 16)) - 16'd8;
      x = 26'($urandom_range(0, 40));
      step(r, s, b, o, j, x);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the MIPS pipeline, directly upstream of the instruction memory. Holds the program counter, drives the memory address, computes the next PC (sequential, branch, jump), and registers the returned instruction word with its PC+4 into the IF/ID pipeline register. Supports decode-stage stalls and redirects, and halts on an illegal fetch address.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_WORDS, 32, number of 32-bit words in instruction memory; legal fetch range is word index 0..IMEM_WORDS-1

- Clk  in  1  pipeline clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; overrides every other input
- Stall  in  1  hazard stall from decode; freezes PC and IF/ID
- Branch  in  1  taken-branch redirect from decode
- BranchOffset  in  16  signed word offset of the branch in IF/ID
- Jump  in  1  jump redirect from decode
- JumpIndex  in  26  jump target index of the jump in IF/ID
- Addr  out  32  fetch address to instruction memory (equals PC register)
- InstrIn  in  32  instruction word from memory, assembled as {Out2, Out1}
- IfIdInstr  out  32  registered instruction word
- IfIdPcPlus4  out  32  registered PC+4 of that instruction
- IfIdValid  out  1  IF/ID holds a real instruction (0 = bubble)
- Fault  out  1  sticky illegal-fetch flag
- FaultPc  out  32  PC that caused the fault

## Operation

- FSM states: BOOT, RUN, HALT.
- BOOT: entered on Reset; lasts exactly one cycle; no capture; IF/ID stays invalid; -> RUN.
- RUN, per rising edge, priority order:
  1. Illegal PC (Addr[1:0] != 0 or Addr>>2 >= IMEM_WORDS): Fault<=1, FaultPc<=PC, IF/ID <= bubble, PC held, -> HALT.
  2. Stall=1: PC, IF/ID unchanged; Branch/Jump ignored this cycle (decode re-asserts them).
  3. Jump=1 and IfIdValid=1: PC <= {IfIdPcPlus4[31:28], JumpIndex, 2'b00}; IF/ID <= bubble (see Configuration).
  4. Branch=1 and IfIdValid=1: PC <= IfIdPcPlus4 + (sext(BranchOffset) << 2); IF/ID <= bubble.
  5. Otherwise: IF/ID <= {InstrIn, PC+4, valid=1}; PC <= PC+4.
- Jump wins over Branch when both asserted.
- Branch/Jump with IfIdValid=0 are ignored (treated as case 5).
- Bubble: IfIdInstr=0, IfIdPcPlus4=0, IfIdValid=0.
- HALT: PC frozen, IF/ID bubble, Fault=1; all inputs except Reset ignored; leaves only via Reset.
- Arithmetic: all adds 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 = 0.

## Timing

- Addr is combinational from the PC register; InstrIn sampled at the same edge that advances PC (memory treated as combinational).
- Fetch-to-IF/ID latency: 1 cycle.
- Redirect penalty: 1 bubble cycle; target fetched on the cycle after the redirect edge.
- Redirect to an illegal target: PC loads it; fault raised on the following edge.
- Fault detection: 1 edge after illegal PC appears on Addr; FaultPc captures it.
- Reset values: PC=Addr=RESET_PC, IfIdInstr=0, IfIdPcPlus4=0, IfIdValid=0, Fault=0, FaultPc=0, state=BOOT.
- Reset mid-operation (any state, including Stall or HALT): next edge applies reset values; pending redirect discarded.

## Configuration

- BRANCH_DELAY_SLOT_EN defined: on a taken Jump/Branch, the instruction currently fetched (the delay slot) is captured normally into IF/ID with valid=1 while PC loads the target; no bubble.
- Undefined: redirect flushes the slot instruction, IF/ID <= bubble as in Operation.

## Test plan

- Reset then free-run, memory words 0..3 = 0x20080001.. : Addr 0,0,4,8,12; IfIdValid first 1 on third edge with IfIdInstr=0x20080001, IfIdPcPlus4=4.
- Stall held 2 cycles at PC=8: Addr stays 8, IF/ID unchanged, then resumes with PC=12.
- Branch with IfIdPcPlus4=8, BranchOffset=16'hFFFE: next Addr=0; IF/ID bubble (no macro) or slot instruction at 8 valid (macro).
- Jump and Branch together, IfIdPcPlus4=0x10, JumpIndex=5: Addr=0x14, Branch ignored; Branch/Jump with IfIdValid=0: sequential PC+4.
- Jump to JumpIndex=32 (Addr=0x80, IMEM_WORDS=32): next edge Fault=1, FaultPc=0x80, IfIdValid=0; Stall/Branch ignored; Reset returns Addr=RESET_PC, Fault=0.
- Misaligned redirect (BranchOffset giving Addr=0x6 impossible; force RESET_PC=2): Fault=1 on first RUN edge, FaultPc=2.
